// File: rtl/log_8_32.sv
// Byte-to-word packer: gathers four valid bytes (first byte in [31:24]) and
// emits one 32-bit word with a single-cycle valid_out strobe.
module log_8_32 #(
  parameter bit GAP_FLUSH = 1'b0
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err,
  output logic [1:0]  dbg_idx
);

  logic [1:0]  idx;
  logic [23:0] acc;

  assign dbg_idx = idx;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      idx       <= 2'd0;
      acc       <= 24'h0;
      data_out  <= 32'h0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err       <= 1'b0;
      if (valid) begin
        if (idx == 2'd3) begin
          data_out  <= {acc, data_in};
          valid_out <= 1'b1;
          idx       <= 2'd0;
        end else begin
          case (idx)
            2'd0:    acc[23:16] <= data_in;
            2'd1:    acc[15:8]  <= data_in;
            default: acc[7:0]   <= data_in;
          endcase
          idx <= idx + 2'd1;
        end
      end else if (GAP_FLUSH && (idx != 2'd0)) begin
        // A gap mid-word abandons the partial word; the next byte starts fresh.
        idx <= 2'd0;
        acc <= 24'h0;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log_8_32.sv
// Bench for log_8_32: a tolerant (GAP_FLUSH=0) and a flushing (GAP_FLUSH=1)
// instance share one byte stream; a monitor checks words against expected queues.
module tb_log_8_32;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b0;
  logic [7:0]  data_in = 8'h0;
  logic        valid   = 1'b0;

  logic [31:0] data_out0, data_out1;
  logic        valid_out0, valid_out1;
  logic        err0, err1;
  logic [1:0]  dbg_idx0, dbg_idx1;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err0_cnt = 0;
  int err1_cnt = 0;
  int vo0_cnt = 0;
  int vo1_cnt = 0;
  bit spacing_on = 1'b0;
  int spacing_epoch = 0;

  log_8_32 #(.GAP_FLUSH(1'b0)) u_keep (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid(valid),
    .data_out(data_out0), .valid_out(valid_out0), .err(err0), .dbg_idx(dbg_idx0)
  );

  log_8_32 #(.GAP_FLUSH(1'b1)) u_flush (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid(valid),
    .data_out(data_out1), .valid_out(valid_out1), .err(err1), .dbg_idx(dbg_idx1)
  );

  // clock / reset block
  always #5 clk_4f = ~clk_4f;

  always_ff @(posedge clk_4f) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_4f);
    data_in = b;
    valid   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_4f);
      valid   = 1'b0;
      data_in = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic push_both(input logic [31:0] w);
    exp_q0.push_back(w);
    exp_q1.push_back(w);
  endtask

  // scoreboard monitor: samples registered outputs away from the rising edge
  initial begin : monitor
    int last_pulse;
    int seen_epoch;
    logic [31:0] e;
    last_pulse = -1;
    seen_epoch = -1;
    forever begin
      @(negedge clk_4f);
      if (reset) begin
        if (valid_out0) begin
          vo0_cnt++;
          if (exp_q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL keep_unexpected_word actual=%h expected=none", data_out0);
          end else begin
            e = exp_q0.pop_front();
            check("keep_word", data_out0, e);
          end
          if (spacing_on) begin
            if (seen_epoch == spacing_epoch && last_pulse >= 0)
              check("keep_pulse_spacing", 32'(cyc - last_pulse), 32'd4);
            last_pulse = cyc;
            seen_epoch = spacing_epoch;
          end
        end
        if (valid_out1) begin
          vo1_cnt++;
          if (exp_q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL flush_unexpected_word actual=%h expected=none", data_out1);
          end else begin
            e = exp_q1.pop_front();
            check("flush_word", data_out1, e);
          end
        end
        if (err0) err0_cnt++;
        if (err1) err1_cnt++;
      end
    end
  end

  // time limit: every run ends on its own
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] w;

    // reset state
    #3;
    check("rst_data_out0", data_out0, 32'h0);
    check("rst_data_out1", data_out1, 32'h0);
    check("rst_flags", {29'h0, valid_out0, valid_out1, err1}, 32'h0);
    @(negedge clk_4f);
    reset = 1'b1;

    // continuous 8 bytes: two words, spacing exactly 4
    spacing_epoch++;
    spacing_on = 1'b1;
    push_both(32'h11223344);
    push_both(32'h55667788);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    idle(4);
    spacing_on = 1'b0;
    check("ph1_word_count0", 32'(vo0_cnt), 32'd2);
    check("ph1_data_held", data_out0, 32'h55667788);

    // gap mid-word: keep instance completes, flush instance discards twice
    exp_q0.push_back(32'hDEADBEEF);
    send_byte(8'hDE); send_byte(8'hAD);
    idle(3);
    send_byte(8'hBE); send_byte(8'hEF);
    idle(4);
    check("ph2_err_keep", 32'(err0_cnt), 32'd0);
    check("ph2_err_flush", 32'(err1_cnt), 32'd2);
    check("ph2_flush_idx", {30'h0, dbg_idx1}, 32'd0);

    // flush then restart: byte after the flush is byte 0 of a new word
    exp_q0.push_back(32'hAABB0102);
    exp_q1.push_back(32'h01020304);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(4);
    check("ph3_err_flush", 32'(err1_cnt), 32'd3);
    check("ph3_data_flush", data_out1, 32'h01020304);
    check("ph3_keep_partial_idx", {30'h0, dbg_idx0}, 32'd2);

    // keep instance holds 03,04 so two more bytes complete a word there
    exp_q0.push_back(32'h03041234);
    send_byte(8'h12); send_byte(8'h34);
    @(negedge clk_4f);
    valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_data0", data_out0, 32'h0);
    check("async_rst_data1", data_out1, 32'h0);
    check("async_rst_flags", {28'h0, valid_out0, valid_out1, err0, err1}, 32'h0);
    check("async_rst_idx", {28'h0, dbg_idx0, dbg_idx1}, 32'h0);
    check("async_rst_err_cnt", 32'(err1_cnt), 32'd3);
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b1;
    push_both(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    idle(3);
    check("post_rst_data1", data_out1, 32'hCAFEF00D);

    // loopback: serializer-order byte stream, 1000 words back to back
    spacing_epoch++;
    spacing_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      push_both(w);
      send_word(w);
    end
    idle(4);
    spacing_on = 1'b0;

    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    check("word_count0", 32'(vo0_cnt), 32'd1006);
    check("word_count1", 32'(vo1_cnt), 32'd1004);
    check("err_total_keep", 32'(err0_cnt), 32'd0);
    check("err_total_flush", 32'(err1_cnt), 32'd3);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_8_32.md
# log_8_32

Byte-to-word packer: the receive-side counterpart of the 32-to-8 serializer. It collects four consecutive valid bytes on `clk_4f` and presents them as one 32-bit word with a single-cycle `valid_out` strobe. Byte order matches the serializer: the first byte received lands in bits [31:24]. It sits after the 8-bit lane of the datapath and restores the 32-bit word stream.

## Interface
- `GAP_FLUSH`, default 0: 0 = gaps in `valid` mid-word are tolerated and the partial word is kept; 1 = a gap mid-word discards the partial word and flags `err`.
- `clk_4f` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `data_in` input 8: byte from the serializer lane; sampled when `valid`=1.
- `valid` input 1: qualifies `data_in` for the current cycle.
- `data_out` output 32: last completed word, registered; held until the next word completes.
- `valid_out` output 1: one-cycle strobe marking a new word on `data_out`.
- `err` output 1: one-cycle strobe, `GAP_FLUSH`=1 only, marking a discarded partial word.

## Operation
- State:
  - 2-bit byte index `idx` (0..3).
  - 24-bit accumulator `acc`, holding bytes 0..2 of the current word.
  - Output registers `data_out`, `valid_out`, `err`.
- Reset (`reset`=0, asynchronous): `idx`=0, `acc`=0, `data_out`=32'h0, `valid_out`=0, `err`=0. A reset mid-word discards the partial bytes with no `err`.
- Edge with `valid`=1 and `idx`<3:
  - Byte stored in `acc` (idx0 -> [23:16], idx1 -> [15:8], idx2 -> [7:0]).
  - `idx`++.
  - `valid_out` <= 0.
- Edge with `valid`=1 and `idx`=3:
  - `data_out` <= {acc[23:0], data_in}.
  - `valid_out` <= 1.
  - `idx` <= 0 (wrap-around).
- Edge with `valid`=0:
  - `valid_out` <= 0.
  - `GAP_FLUSH`=0: `idx` and `acc` hold.
  - `GAP_FLUSH`=1 and `idx`!=0: `idx` <= 0, `acc` <= 0, `err` <= 1 for one cycle.
  - `GAP_FLUSH`=1 and `idx`=0: no effect, `err` stays 0.
- `err` is 0 on every edge not covered by the flush case above. With `GAP_FLUSH`=0, `err` is tied 0.
- `data_out` changes only when a word completes. It is never cleared except by reset.
- No backpressure: the block always accepts a byte when `valid`=1.

## Timing
- Latency: the 4th byte is sampled at edge E; `data_out`/`valid_out` are valid from E until E+1.
- `valid_out` is a one-cycle pulse. With continuous `valid`, words complete every 4 cycles (pulse spacing is exactly 4).
- `err` is asserted in the cycle after the first `valid`=0 edge seen with a partial word.
- A byte arriving on the edge right after a flush is taken as byte 0 of a new word.
- Simultaneous reset and clock edge: reset wins; all outputs read 0.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then 8 continuous bytes 0x11,0x22,...,0x88 with `valid`=1:
  - 0x11223344 with `valid_out`=1 one cycle after the 4th byte;
  - 0x55667788 exactly 4 cycles later;
  - `valid_out`=0 otherwise.
- `GAP_FLUSH`=0, bytes 0xDE,0xAD, 3 idle cycles, then 0xBE,0xEF:
  - `data_out`=0xDEADBEEF, one `valid_out` pulse;
  - `err` stays 0.
- `GAP_FLUSH`=1, bytes 0xAA,0xBB, 1 idle cycle, then 0x01,0x02,0x03,0x04:
  - `err` pulses once;
  - `data_out`=0x01020304;
  - no word containing 0xAA is ever output.
- `reset`=0 asserted asynchronously between edges after 2 bytes:
  - outputs drop to 0 immediately, with no clock edge;
  - after release, 4 bytes 0xCAFEF00D produce `data_out`=0xCAFEF00D.
- Loopback: random 32-bit words drive `log_32_8`, its byte stream drives `log_8_32` (1000 words):
  - every received word equals the sent word, in order;
  - `valid_out` count equals the number of words sent.
